pio_flow_ctrl: RTL and testbench

- Execution-control front end of a PIO state machine; the counterpart of the program counter.
- Consumes the 16-bit instruction fetched at the current pc.
- Drives the program counter's pc_en, jump_en and jump inputs.
- Implements JMP conditions, WAIT stalls, SET of the X/Y scratch registers, and per-instruction delay cycles.
- All other opcodes are single-cycle NOPs.

---
 rtl/pio_flow_ctrl.sv | 153 +++++++++++++++
 tb/tb_pio_flow_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pio_flow_ctrl.sv
// PIO execution-control front end: decodes the fetched instruction and drives the
// program counter, handling JMP conditions, WAIT stalls, SET of X/Y and delay cycles.
module pio_flow_ctrl #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DELAY_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [15:0]       instr,
    input  logic              jmp_pin,
    input  logic              wait_pin,
    input  logic              osr_empty,
    output logic              pc_en,
    output logic              jump_en,
    output logic [4:0]        jump,
    output logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y,
    output logic              stalled
);

    localparam logic [0:0] StExec  = 1'b0;
    localparam logic [0:0] StDelay = 1'b1;

    localparam logic [2:0] OpJmp  = 3'b000;
    localparam logic [2:0] OpWait = 3'b001;
    localparam logic [2:0] OpSet  = 3'b111;

    localparam logic [2:0] CondAlways  = 3'b000;
    localparam logic [2:0] CondXZero   = 3'b001;
    localparam logic [2:0] CondXDec    = 3'b010;
    localparam logic [2:0] CondYZero   = 3'b011;
    localparam logic [2:0] CondYDec    = 3'b100;
    localparam logic [2:0] CondXNeY    = 3'b101;
    localparam logic [2:0] CondPin     = 3'b110;
    localparam logic [2:0] CondOsrFull = 3'b111;

    localparam logic [2:0] DestX = 3'b001;
    localparam logic [2:0] DestY = 3'b010;

    localparam logic [DATA_W-1:0]  DataOne  = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DELAY_W-1:0] DelayOne = {{(DELAY_W-1){1'b0}}, 1'b1};
    localparam logic [DELAY_W-1:0] DelayZero = '0;

    logic [0:0]         state_q, state_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]  x_q, x_d;
    logic [DATA_W-1:0]  y_q, y_d;

    logic [2:0]         opcode;
    logic [DELAY_W-1:0] delay;
    logic [2:0]         cond;
    logic [4:0]         addr;
    logic               run;
    logic               complete;
    logic               cond_ok;
    logic [DATA_W-1:0]  set_data;

    assign opcode   = instr[15:13];
    assign delay    = instr[8+DELAY_W-1:8];
    assign cond     = instr[7:5];
    assign addr     = instr[4:0];
    assign set_data = {{(DATA_W-5){1'b0}}, addr};

    // Outputs stay quiet while reset is held, even though state already reads EXEC.
    assign run = enable & ~rst;

    always_comb begin
        cond_ok = 1'b0;
        unique case (cond)
            CondAlways:  cond_ok = 1'b1;
            CondXZero:   cond_ok = (x_q == '0);
            CondXDec:    cond_ok = (x_q != '0);
            CondYZero:   cond_ok = (y_q == '0);
            CondYDec:    cond_ok = (y_q != '0);
            CondXNeY:    cond_ok = (x_q != y_q);
            CondPin:     cond_ok = jmp_pin;
            CondOsrFull: cond_ok = ~osr_empty;
            default:     cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        complete = 1'b0;
        pc_en    = 1'b0;
        jump_en  = 1'b0;
        stalled  = 1'b0;

        if (state_q == StExec) begin
            if (run) begin
                case (opcode)
                    OpJmp: begin
                        complete = 1'b1;
                        jump_en  = cond_ok;
                        // Post-decrement happens whether or not the jump is taken.
                        if (cond == CondXDec) x_d = x_q - DataOne;
                        if (cond == CondYDec) y_d = y_q - DataOne;
                    end
                    OpWait: begin
                        if (wait_pin == instr[7]) begin
                            complete = 1'b1;
                        end else begin
                            stalled = 1'b1;
                        end
                    end
                    OpSet: begin
                        complete = 1'b1;
                        if (cond == DestX) x_d = set_data;
                        if (cond == DestY) y_d = set_data;
                    end
                    default: complete = 1'b1;
                endcase

                if (complete) begin
                    pc_en = 1'b1;
                    if (delay != DelayZero) begin
                        cnt_d   = delay;
                        state_d = StDelay;
                    end
                end
            end
        end else begin
            stalled = ~rst;
            if (run) begin
                cnt_d = cnt_q - DelayOne;
                if (cnt_q == DelayOne) state_d = StExec;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StExec;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign jump = addr;
    assign x    = x_q;
    assign y    = y_q;

endmodule

// File: tb/tb_pio_flow_ctrl.sv
// Directed bench for pio_flow_ctrl: inputs change just after posedge, combinational
// outputs are checked 1 time unit later, registered X/Y after the following edge.
module tb_pio_flow_ctrl;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] instr;
    logic        jmp_pin;
    logic        wait_pin;
    logic        osr_empty;
    logic        pc_en;
    logic        jump_en;
    logic [4:0]  jump;
    logic [31:0] x;
    logic [31:0] y;
    logic        stalled;

    int unsigned n_tests;
    int unsigned n_fail;

    pio_flow_ctrl #(
        .DATA_W (32),
        .DELAY_W(5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .instr    (instr),
        .jmp_pin  (jmp_pin),
        .wait_pin (wait_pin),
        .osr_empty(osr_empty),
        .pc_en    (pc_en),
        .jump_en  (jump_en),
        .jump     (jump),
        .x        (x),
        .y        (y),
        .stalled  (stalled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock edge, then settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the three control outputs for the currently driven inputs.
    task automatic check_ctl(input string tag, input logic e_pc, input logic e_je,
                             input logic e_st);
        #1;
        check_eq({tag, ".pc_en"}, {63'd0, pc_en}, {63'd0, e_pc});
        check_eq({tag, ".jump_en"}, {63'd0, jump_en}, {63'd0, e_je});
        check_eq({tag, ".stalled"}, {63'd0, stalled}, {63'd0, e_st});
    endtask

    // Execute one single-cycle instruction and step past it.
    task automatic exec(input logic [15:0] ins);
        instr = ins;
        tick();
    endtask

    logic        exp_je [4];
    logic [31:0] exp_x  [4];

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        enable    = 1'b0;
        instr     = 16'h0007;
        jmp_pin   = 1'b0;
        wait_pin  = 1'b0;
        osr_empty = 1'b1;

        // Reset state
        #3;
        check_eq("rst.x", {32'd0, x}, 64'd0);
        check_eq("rst.y", {32'd0, y}, 64'd0);
        enable = 1'b1;
        check_ctl("rst.held", 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        // JMP always 7 on the first enabled cycle
        instr = 16'h0007;
        check_ctl("jmp_always", 1'b1, 1'b1, 1'b0);
        check_eq("jmp_always.jump", {59'd0, jump}, 64'd7);
        tick();

        // SET X 3, then JMP X-- four times
        exec(16'hE023);
        check_eq("set_x3", {32'd0, x}, 64'd3);
        exp_je = '{1'b1, 1'b1, 1'b1, 1'b0};
        exp_x  = '{32'd2, 32'd1, 32'd0, 32'hFFFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            instr = 16'h0042;
            check_ctl($sformatf("xdec%0d", i), 1'b1, exp_je[i], 1'b0);
            check_eq($sformatf("xdec%0d.jump", i), {59'd0, jump}, 64'd2);
            tick();
            check_eq($sformatf("xdec%0d.x", i), {32'd0, x}, {32'd0, exp_x[i]});
        end

        // X!=Y
        exec(16'hE045);
        exec(16'hE025);
        check_eq("set_y5", {32'd0, y}, 64'd5);
        instr = 16'h00A4;
        check_ctl("xney.eq", 1'b1, 1'b0, 1'b0);
        tick();
        exec(16'hE024);
        instr = 16'h00A4;
        check_ctl("xney.ne", 1'b1, 1'b1, 1'b0);
        tick();

        // JMP PIN and !OSRE
        instr = 16'h00C1;
        jmp_pin = 1'b1;
        check_ctl("jpin", 1'b1, 1'b1, 1'b0);
        tick();
        instr = 16'h00E1;
        check_ctl("osre", 1'b1, 1'b0, 1'b0);
        tick();

        // NOP with delay 3
        instr = 16'hA300;
        check_ctl("nop_d3", 1'b1, 1'b0, 1'b0);
        tick();
        instr = 16'h0007;
        for (int i = 0; i < 3; i++) begin
            check_ctl($sformatf("nop_d3.stall%0d", i), 1'b0, 1'b0, 1'b1);
            tick();
        end
        check_ctl("nop_d3.next", 1'b1, 1'b1, 1'b0);
        tick();

        // WAIT pin high, 4 unsatisfied cycles
        instr    = 16'h2080;
        wait_pin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_ctl($sformatf("wait.stall%0d", i), 1'b0, 1'b0, 1'b1);
            tick();
        end
        wait_pin = 1'b1;
        check_ctl("wait.done", 1'b1, 1'b0, 1'b0);
        tick();

        // WAIT with delay 2: delay starts only after the wait completes
        instr    = 16'h2280;
        wait_pin = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_ctl($sformatf("waitd.stall%0d", i), 1'b0, 1'b0, 1'b1);
            tick();
        end
        wait_pin = 1'b1;
        check_ctl("waitd.done", 1'b1, 1'b0, 1'b0);
        tick();
        instr = 16'h0007;
        for (int i = 0; i < 2; i++) begin
            check_ctl($sformatf("waitd.delay%0d", i), 1'b0, 1'b0, 1'b1);
            tick();
        end
        check_ctl("waitd.next", 1'b1, 1'b1, 1'b0);
        tick();

        // enable low mid-DELAY freezes the counter
        instr = 16'hA300;
        tick();
        instr = 16'h0007;
        check_ctl("dis.d0", 1'b0, 1'b0, 1'b1);
        tick();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_ctl($sformatf("dis.frozen%0d", i), 1'b0, 1'b0, 1'b1);
            tick();
        end
        enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check_ctl($sformatf("dis.resume%0d", i), 1'b0, 1'b0, 1'b1);
            tick();
        end
        check_ctl("dis.next", 1'b1, 1'b1, 1'b0);
        tick();

        // Reset during a 10-cycle DELAY
        exec(16'hE029);
        exec(16'hAA00);
        instr = 16'h0007;
        for (int i = 0; i < 3; i++) begin
            check_ctl($sformatf("rstd.stall%0d", i), 1'b0, 1'b0, 1'b1);
            tick();
        end
        rst = 1'b1;
        #1;
        check_eq("rstd.x", {32'd0, x}, 64'd0);
        check_eq("rstd.y", {32'd0, y}, 64'd0);
        check_ctl("rstd.held", 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        check_ctl("rstd.exec", 1'b1, 1'b1, 1'b0);
        tick();
        check_ctl("rstd.exec2", 1'b1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
